max7219_if_arbiter: RTL
=======================

MAX7219_IF_ARBITER -- requirements
Module: max7219_if_arbiter

Interface
REQ-001 Parameter G_DATA_WIDTH, default 16: width of one MAX7219 serial word.
REQ-002 Parameter G_FRAME_TIMEOUT, default 1000: idle cycles allowed between words of a frame before a forced release; legal range 1..2^16-1.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 i_req  in  2  per-requester level request; bit k = requester k.
REQ-006 o_grant  out  2  one-hot ownership of the shared interface, or all-zero.
REQ-007 i_start  in  2  per-requester one-cycle word start pulse.
REQ-008 i_en_load0 / i_en_load1  in  1 each  word closes the frame (load strobe after shift).
REQ-009 i_data0 / i_data1  in  G_DATA_WIDTH each  word to serialise.
REQ-010 o_done  out  2  per-requester one-cycle word-complete pulse.
REQ-011 o_timeout  out  1  one-cycle pulse on forced release.
REQ-012 o_max7219_if_start  out  1  start pulse to the max7219_if.
REQ-013 o_max7219_if_en_load  out  1  en_load to the max7219_if, held during the word.
REQ-014 o_max7219_if_data  out  G_DATA_WIDTH  data to the max7219_if, held during the word.
REQ-015 i_max7219_if_done  in  1  word-complete pulse from the max7219_if.

Function
REQ-016 FSM states: IDLE, GRANTED, BUSY; reset state IDLE.
REQ-017 IDLE: if any i_req bit set, the next cycle sets o_grant to the winner and enters GRANTED; one-cycle grant latency.
REQ-018 Arbitration is round-robin: on simultaneous requests, the winner is the requester not granted last; after reset, requester 0 wins.
REQ-019 GRANTED: an i_start from the owner latches its i_data/i_en_load, pulses o_max7219_if_start the next cycle and enters BUSY.
REQ-020 i_start from a non-owner, or in IDLE/BUSY, is ignored with no side effect.
REQ-021 BUSY: o_max7219_if_data/en_load stay stable; i_max7219_if_done pulses o_done[owner] the next cycle.
REQ-022 On done, a latched en_load=1 releases the grant, clears o_grant, enters IDLE and updates the round-robin pointer; en_load=0 returns to GRANTED.
REQ-023 A frame of N words with en_load=0 followed by one word with en_load=1 shall never be interleaved with another requester's words.
REQ-024 GRANTED runs a 16-bit idle counter, cleared on entry and on each owner i_start; reaching G_FRAME_TIMEOUT forces release to IDLE and pulses o_timeout.
REQ-025 The owner deasserting i_req in GRANTED releases to IDLE the next cycle without a timeout pulse.
REQ-026 The owner deasserting i_req in BUSY has no effect until done; the FSM then enters GRANTED and releases on the following cycle.
REQ-027 i_max7219_if_done outside BUSY is ignored.
REQ-028 Simultaneous owner i_start and timeout terminal count: the start wins, with no timeout pulse.
REQ-029 After release, IDLE always lasts at least one cycle before a new grant.

Reset
REQ-030 rst_n low asynchronously forces the following, including mid-word in BUSY: FSM IDLE, o_grant 0, o_done 0, o_timeout 0, o_max7219_if_start 0, o_max7219_if_en_load 0, o_max7219_if_data 0, counter 0, round-robin pointer to favour requester 0.
REQ-031 The first grant is issued no earlier than the second rising edge after rst_n deasserts.

Structure
REQ-032 The FSM state type, requester-count constant (2) and timeout counter width (16) belong in shared package pkg_max7219.
REQ-033 Round-robin selection is sub-module max7219_rr_arb (request vector plus last-grant in, one-hot grant out); everything else is in the top.
REQ-034 The block sits between max7219_cmd_decod-class requesters and one max7219_if, and is port-transparent to both.

Verification
REQ-035 Single owner: req0=1, start0 with data 0x0C01 en_load=1 -> grant 01 after 1 cycle, if_start 1 cycle after start0, done0 1 cycle after if_done, grant 00.
REQ-036 Contention: req=11 in the same cycle after reset -> grant 01 first; after a frame closes -> grant 10; then repeated req=11 -> grants alternate.
REQ-037 Frame lock: req0 sends 0x0100 and 0x0200 (en_load=0) then 0x0300 (en_load=1) while req1=1 -> the if sees all 3 words, in order, before grant 10.
REQ-038 Timeout: G_FRAME_TIMEOUT=10, owner sends 1 en_load=0 word then idles -> o_timeout pulse 10 cycles after GRANTED re-entry; grant passes to a pending requester.
REQ-039 Reset in BUSY: rst_n low 3 cycles during a word -> all outputs 0 immediately; after release, no if_start until a new grant and start.
REQ-040 Ignored strobes: start1 while requester 0 owns the interface, plus a spurious if_done in GRANTED -> no if_start, no done pulse, state unchanged.

Source files
------------

// File: rtl/max7219_if_arbiter_pkg.sv
// Shared definitions for the MAX7219 interface arbiter: FSM states,
// requester count and frame-timeout counter width.
package pkg_max7219;

    localparam int unsigned C_NUM_REQ   = 2;
    localparam int unsigned C_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    // Index of the set bit in a two-requester one-hot vector.
    function automatic logic onehot_to_idx(input logic [C_NUM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/max7219_if_arbiter_rr_arb.sv
// Two-way round-robin selector: on contention the requester that was not
// granted last wins.
module max7219_rr_arb
    import pkg_max7219::*;
(
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [C_NUM_REQ-1:0] last_grant,
    output logic [C_NUM_REQ-1:0] grant
);

    // Winner selection from the request vector and last-grant history.
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last_grant[0] ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/max7219_if_arbiter.sv
// Arbitrates two command requesters onto one max7219_if, holding ownership
// for a whole frame (words up to and including the en_load word).
module max7219_if_arbiter
    import pkg_max7219::*;
#(
    parameter int G_DATA_WIDTH    = 16,
    parameter int G_FRAME_TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_NUM_REQ-1:0]    i_req,
    output logic [C_NUM_REQ-1:0]    o_grant,
    input  logic [C_NUM_REQ-1:0]    i_start,
    input  logic                    i_en_load0,
    input  logic                    i_en_load1,
    input  logic [G_DATA_WIDTH-1:0] i_data0,
    input  logic [G_DATA_WIDTH-1:0] i_data1,
    output logic [C_NUM_REQ-1:0]    o_done,
    output logic                    o_timeout,
    output logic                    o_max7219_if_start,
    output logic                    o_max7219_if_en_load,
    output logic [G_DATA_WIDTH-1:0] o_max7219_if_data,
    input  logic                    i_max7219_if_done
);

    localparam logic [C_CNT_WIDTH-1:0] TIMEOUT_C = G_FRAME_TIMEOUT[C_CNT_WIDTH-1:0];

    state_t                   state_r, state_s;
    logic [C_NUM_REQ-1:0]     grant_r, grant_s;
    logic [C_NUM_REQ-1:0]     last_r, last_s;
    logic [C_CNT_WIDTH-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic [G_DATA_WIDTH-1:0]  data_r, data_s, sel_data_s;
    logic                     en_load_r, en_load_s, sel_en_load_s;
    logic                     if_start_r, if_start_s;
    logic [C_NUM_REQ-1:0]     done_r, done_s;
    logic                     timeout_r, timeout_s;
    logic                     ready_r;
    logic [C_NUM_REQ-1:0]     arb_grant_s;
    logic                     owner_s;

    max7219_rr_arb u_rr_arb (
        .req        (i_req),
        .last_grant (last_r),
        .grant      (arb_grant_s)
    );

    assign owner_s       = onehot_to_idx(grant_r);
    assign sel_data_s    = owner_s ? i_data1 : i_data0;
    assign sel_en_load_s = owner_s ? i_en_load1 : i_en_load0;
    assign cnt_inc_s     = cnt_r + 16'd1;

    // Next-state and registered-output computation for the ownership FSM.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        last_s     = last_r;
        cnt_s      = cnt_r;
        data_s     = data_r;
        en_load_s  = en_load_r;
        if_start_s = 1'b0;
        done_s     = 2'b00;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // ready_r keeps the first post-reset edge grant-free.
                if (ready_r && (i_req != 2'b00)) begin
                    state_s = ST_GRANTED;
                    grant_s = arb_grant_s;
                    last_s  = arb_grant_s;
                    cnt_s   = {C_CNT_WIDTH{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                // An owner start beats both release and the timeout terminal count.
                if (i_start[owner_s]) begin
                    state_s    = ST_BUSY;
                    data_s     = sel_data_s;
                    en_load_s  = sel_en_load_s;
                    if_start_s = 1'b1;
                    cnt_s      = {C_CNT_WIDTH{1'b0}};
                end else if (!i_req[owner_s]) begin
                    state_s = ST_IDLE;
                    grant_s = 2'b00;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_s   = ST_IDLE;
                    grant_s   = 2'b00;
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_BUSY: begin
                if (i_max7219_if_done) begin
                    done_s = grant_r;
                    if (en_load_r) begin
                        state_s = ST_IDLE;
                        grant_s = 2'b00;
                    end else begin
                        state_s = ST_GRANTED;
                        cnt_s   = {C_CNT_WIDTH{1'b0}};
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 2'b00;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= 2'b00;
            last_r     <= 2'b10;
            cnt_r      <= {C_CNT_WIDTH{1'b0}};
            data_r     <= {G_DATA_WIDTH{1'b0}};
            en_load_r  <= 1'b0;
            if_start_r <= 1'b0;
            done_r     <= 2'b00;
            timeout_r  <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            last_r     <= last_s;
            cnt_r      <= cnt_s;
            data_r     <= data_s;
            en_load_r  <= en_load_s;
            if_start_r <= if_start_s;
            done_r     <= done_s;
            timeout_r  <= timeout_s;
            ready_r    <= 1'b1;
        end
    end

    assign o_grant              = grant_r;
    assign o_done               = done_r;
    assign o_timeout            = timeout_r;
    assign o_max7219_if_start   = if_start_r;
    assign o_max7219_if_en_load = en_load_r;
    assign o_max7219_if_data    = data_r;

endmodule
